// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath width and stack opcode constants
package cpu_pkg;
  localparam int CPU_DATA_W = 32;
  localparam logic [3:0] PUSH = 4'b1000;
  localparam logic [3:0] POP  = 4'b1001;
  localparam logic [3:0] SADD = 4'b1010;
  localparam logic [3:0] SMLT = 4'b1011;
endpackage

// File: rtl/stack_ram.sv
// stack_ram: single write port, asynchronous read port storage for the data stack
module stack_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/data_stack.sv
// data_stack: LIFO operand stack with combinational top-of-stack read
// Sticky ovf/unf flags are built only when DATA_STACK_ERR_EN is defined.
module data_stack
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [DATA_W-1:0]      push_data,
  output logic [DATA_W-1:0]      top_data,
  output logic [$clog2(DEPTH):0] sp,
  output logic                   empty,
  output logic                   full,
  output logic                   ovf,
  output logic                   unf
);
  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;
  logic [AW:0]       r_sp;
  logic              w_empty, w_full, w_swap, w_inc, w_dec, w_we;
  logic [AW-1:0]     w_top_idx, w_waddr;
  logic [DATA_W-1:0] w_rdata;
  assign w_empty   = r_sp == '0;
  assign w_full    = r_sp == SPW'(DEPTH);
  assign w_swap    = push & pop & ~w_empty;
  // an empty push+pop degenerates to a plain push
  assign w_inc     = push & (~pop | w_empty) & ~w_full;
  assign w_dec     = pop & ~push & ~w_empty;
  assign w_we      = rst_n & ~flush & (w_swap | w_inc);
  assign w_top_idx = AW'(r_sp - SPW'(1));
  assign w_waddr   = w_swap ? w_top_idx : r_sp[AW-1:0];
  stack_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(push_data),
    .i_raddr(w_top_idx),
    .o_rdata(w_rdata)
  );
  always_ff @(posedge clk)
    if (!rst_n)     r_sp <= '0;
    else if (flush) r_sp <= '0;
    else if (w_inc) r_sp <= r_sp + SPW'(1);
    else if (w_dec) r_sp <= r_sp - SPW'(1);
  assign top_data = w_empty ? '0 : w_rdata;
  assign sp       = r_sp;
  assign empty    = w_empty;
  assign full     = w_full;
`ifdef DATA_STACK_ERR_EN
  logic r_ovf, r_unf;
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (!flush) begin
      r_ovf <= r_ovf | (push & ~pop & w_full);
      r_unf <= r_unf | (pop & w_empty);
    end
  assign ovf = r_ovf;
  assign unf = r_unf;
`else
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif
endmodule

// File: tb/tb_data_stack.sv
// tb_data_stack: directed and random stimulus against a queue-based stack model
module tb_data_stack;
  localparam int DEPTH = 16;
`ifdef DATA_STACK_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0, push = 1'b0, pop = 1'b0, flush = 1'b0;
  logic [31:0] push_data = '0;
  logic [31:0] top_data;
  logic [4:0]  sp;
  logic        empty, full, ovf, unf;
  int checks = 0, failures = 0;
  logic [31:0] q[$];
  bit m_ovf = 1'b0, m_unf = 1'b0, started = 1'b0;

  data_stack #(.DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(flush),
    .push_data(push_data), .top_data(top_data), .sp(sp), .empty(empty),
    .full(full), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      started = 1'b1;
    end else if (flush) q.delete();
    else if (push && pop) begin
      if (q.size() == 0) begin
        q.push_back(push_data);
        m_unf = 1'b1;
      end else q[q.size()-1] = push_data;
    end else if (push) begin
      if (q.size() < DEPTH) q.push_back(push_data);
      else m_ovf = 1'b1;
    end else if (pop) begin
      if (q.size() > 0) void'(q.pop_back());
      else m_unf = 1'b1;
    end
  end

  always @(negedge clk)
    if (started) begin
      check("sp", 32'(sp), 32'(q.size()));
      check("top_data", top_data, q.size() > 0 ? q[q.size()-1] : 32'd0);
      check("empty", 32'(empty), 32'(q.size() == 0));
      check("full", 32'(full), 32'(q.size() == DEPTH));
      check("ovf", 32'(ovf), 32'(ERR & m_ovf));
      check("unf", 32'(unf), 32'(ERR & m_unf));
    end

  task automatic cyc(input bit r, input bit f, input bit p, input bit o, input logic [31:0] d);
    @(negedge clk);
    #1;
    rst_n = r; flush = f; push = p; pop = o; push_data = d;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 0);
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 32'd77);
    check("rst_sp", 32'(sp), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_top", top_data, 0);
    // push 5, 7, -3 then pop three times
    cyc(1, 0, 1, 0, 32'd5);
    cyc(1, 0, 1, 0, 32'd7);
    cyc(1, 0, 1, 0, 32'hFFFF_FFFD);
    check("lifo_sp", 32'(sp), 3);
    check("lifo_top", top_data, 32'hFFFF_FFFD);
    check("model_size", 32'(q.size()), 3);
    cyc(1, 0, 0, 1, 0);
    check("pop1_top", top_data, 7);
    cyc(1, 0, 0, 1, 0);
    check("pop2_top", top_data, 5);
    cyc(1, 0, 0, 1, 0);
    check("pop3_top", top_data, 0);
    check("pop3_empty", 32'(empty), 1);
    cyc(1, 0, 0, 1, 0);
    check("unf_sp", 32'(sp), 0);
    check("unf_top", top_data, 0);
    check("unf_flag", 32'(unf), 32'(ERR));
    cyc(1, 0, 1, 0, 32'd4);
    check("after_unf_sp", 32'(sp), 1);
    check("after_unf_top", top_data, 4);
    // fill to DEPTH, then overflow
    cyc(0, 0, 0, 0, 0);
    for (int i = 1; i <= DEPTH; i++) cyc(1, 0, 1, 0, 32'(i));
    check("fill_full", 32'(full), 1);
    check("fill_sp", 32'(sp), 16);
    check("fill_top", top_data, 16);
    cyc(1, 0, 1, 0, 32'd99);
    check("ovf_sp", 32'(sp), 16);
    check("ovf_top", top_data, 16);
    check("ovf_flag", 32'(ovf), 32'(ERR));
    check("model_ovf", 32'(m_ovf), 1);
    cyc(1, 0, 1, 1, 32'd55);
    check("full_swap_sp", 32'(sp), 16);
    check("full_swap_top", top_data, 55);
    // simultaneous push/pop, non-empty and empty
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 32'd10);
    cyc(1, 0, 1, 0, 32'd20);
    cyc(1, 0, 1, 1, 32'd30);
    check("swap_sp", 32'(sp), 2);
    check("swap_top", top_data, 30);
    check("swap_unf", 32'(unf), 0);
    cyc(1, 0, 0, 1, 0);
    check("swap_under", top_data, 10);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 1, 1, 32'd8);
    check("empty_swap_sp", 32'(sp), 1);
    check("empty_swap_top", top_data, 8);
    check("empty_swap_unf", 32'(unf), 32'(ERR));
    // flush beats push and keeps flags
    cyc(1, 0, 1, 0, 32'd1);
    cyc(1, 0, 1, 0, 32'd2);
    cyc(1, 1, 1, 0, 32'd3);
    check("flush_sp", 32'(sp), 0);
    check("flush_empty", 32'(empty), 1);
    check("flush_unf", 32'(unf), 32'(ERR));
    cyc(1, 1, 0, 1, 0);
    check("flush_pop_unf", 32'(unf), 32'(ERR));
    cyc(1, 0, 1, 0, 32'd6);
    cyc(0, 0, 1, 0, 32'd9);
    check("rst_push_sp", 32'(sp), 0);
    check("rst_push_ovf", 32'(ovf), 0);
    check("rst_push_unf", 32'(unf), 0);
    cyc(1, 0, 0, 1, 0);
    check("post_rst_top", top_data, 0);
    idle();
    // random traffic, checked every cycle by the model
    for (int i = 0; i < 600; i++) begin
      automatic int u = $urandom_range(0, 99);
      cyc(u != 0, u == 1 || u == 2, $urandom_range(0, 2) != 0 || u > 80,
          $urandom_range(0, 1) == 1 && u < 70, $urandom);
    end
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
